// File: rtl/actor_merge_rr.sv
// Round-robin N-to-1 token merge feeding a one-entry output buffer.
// in_ACK is granted combinationally; the granted token appears on out_* after the next edge.
module actor_merge_rr #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned N_CH   = 4,
    parameter int unsigned CNT_W  = 32
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic [N_CH*DATA_W-1:0]  in_DATA,
    input  logic [N_CH-1:0]         in_SEND,
    input  logic [N_CH*16-1:0]      in_COUNT,
    output logic [N_CH-1:0]         in_ACK,
    output logic [DATA_W-1:0]       out_DATA,
    output logic [$clog2(N_CH)-1:0] out_TAG,
    output logic                    out_SEND,
    output logic [15:0]             out_COUNT,
    input  logic                    out_ACK,
    output logic [CNT_W-1:0]        tokens_total
);
    localparam int unsigned TAG_W = $clog2(N_CH);

    localparam logic StEmpty = 1'b0;
    localparam logic StFull  = 1'b1;

    logic              state_q, state_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic [TAG_W-1:0]  ptr_q, ptr_d;
    logic [CNT_W-1:0]  total_q, total_d;

    logic              grant_vld;
    logic [TAG_W-1:0]  grant_idx;
    logic [TAG_W-1:0]  cand;
    logic [TAG_W-1:0]  ptr_nxt;
    logic              can_accept;
    logic              accept;

    // Per-channel counts carry no weight in arbitration.
    logic unused_count;
    assign unused_count = ^in_COUNT;

    // First requesting channel at or after ptr, wrapping modulo N_CH.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int k = 0; k < N_CH; k++) begin
            cand = TAG_W'((32'(ptr_q) + 32'(k)) % N_CH);
            if (!grant_vld && in_SEND[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
    end

    assign ptr_nxt    = (grant_idx == TAG_W'(N_CH - 1)) ? '0 : grant_idx + 1'b1;
    assign can_accept = (state_q == StEmpty) || out_ACK;
    // Gating with RESET keeps in_ACK low for the whole reset pulse, not just after an edge.
    assign accept     = grant_vld && can_accept && !RESET;

    always_comb begin
        in_ACK  = '0;
        state_d = state_q;
        data_d  = data_q;
        tag_d   = tag_q;
        ptr_d   = ptr_q;
        total_d = total_q;
        if (accept) begin
            in_ACK[grant_idx] = 1'b1;
            state_d = StFull;
            data_d  = in_DATA[32'(grant_idx) * DATA_W +: DATA_W];
            tag_d   = grant_idx;
            ptr_d   = ptr_nxt;
            total_d = total_q + 1'b1;
        end else if (state_q == StFull && out_ACK) begin
            state_d = StEmpty;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= StEmpty;
            data_q  <= '0;
            tag_q   <= '0;
            ptr_q   <= '0;
            total_q <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            tag_q   <= tag_d;
            ptr_q   <= ptr_d;
            total_q <= total_d;
        end
    end

    assign out_SEND     = (state_q == StFull);
    assign out_COUNT    = {15'd0, out_SEND};
    assign out_DATA     = data_q;
    assign out_TAG      = tag_q;
    assign tokens_total = total_q;

endmodule

// File: doc/actor_merge_rr.md
ACTOR_MERGE_RR -- requirements
Module: actor_merge_rr

Interface
REQ-001 Parameter DATA_W, 8, bit width of each token.
REQ-002 Parameter N_CH, 4, number of input channels, legal range 2..16.
REQ-003 Parameter CNT_W, 32, width of the total-token counter.
REQ-004 CLK  input  1  single clock, all state updates on rising edge.
REQ-005 RESET  input  1  asynchronous, active-high reset.
REQ-006 in_DATA  input  N_CH*DATA_W  per-channel token data; channel i occupies bits [i*DATA_W +: DATA_W].
REQ-007 in_SEND  input  N_CH  channel i has a token available.
REQ-008 in_COUNT  input  N_CH*16  per-channel available-token count; informational only, ignored by arbitration.
REQ-009 in_ACK  output  N_CH  one-cycle consume strobe to channel i.
REQ-010 out_DATA  output  DATA_W  buffered token data.
REQ-011 out_TAG  output  clog2(N_CH)  source channel index of the buffered token.
REQ-012 out_SEND  output  1  output buffer holds a valid token.
REQ-013 out_COUNT  output  16  constant 1 while out_SEND is high, else 0.
REQ-014 out_ACK  input  1  downstream consumes the buffered token this cycle; ignored while out_SEND is low.
REQ-015 tokens_total  output  CNT_W  count of tokens accepted since reset.

Function
REQ-016 The output buffer SHALL be a one-entry register with two states: EMPTY (out_SEND=0) and FULL (out_SEND=1).
REQ-017 can_accept SHALL equal EMPTY or (FULL and out_ACK).
REQ-018 Round-robin pointer ptr SHALL select the first channel with in_SEND high, searching ptr, ptr+1, ... wrapping modulo N_CH.
REQ-019 in_ACK[g] SHALL be combinational, high only for the granted channel g and only when can_accept=1; at most one bit of in_ACK SHALL be high in any cycle.
REQ-020 On a cycle with in_ACK[g]=1, the next edge SHALL load out_DATA from channel g and out_TAG=g, set FULL, and set ptr=(g+1) mod N_CH.
REQ-021 FULL with out_ACK=1 and no grant SHALL go to EMPTY on the next edge.
REQ-022 FULL with out_ACK=1 and a grant SHALL stay FULL with the new token (throughput of 1 token/cycle, latency 1 cycle from in_ACK to out_SEND).
REQ-023 FULL with out_ACK=0 SHALL hold out_DATA and out_TAG stable and issue no in_ACK.
REQ-024 ptr SHALL remain unchanged on cycles without a grant.
REQ-025 tokens_total SHALL increment by 1 on each edge following an in_ACK, wrapping from all-ones to 0.
REQ-026 When all in_SEND bits are 0, no in_ACK SHALL be asserted, and the state SHALL follow REQ-021 and REQ-023.

Reset
REQ-027 RESET=1 SHALL immediately force EMPTY, out_SEND=0, out_COUNT=0, out_DATA=0, out_TAG=0, ptr=0, tokens_total=0, and in_ACK=0, independent of CLK.
REQ-028 A reset asserted mid-transfer SHALL discard the buffered token without asserting out_SEND again.
REQ-029 The first grant after reset release SHALL be evaluated starting from channel 0.

Verification
REQ-030 Reset, then in_SEND=4'b0100 with ch2 data=0x5A and out_ACK=1 -> in_ACK=4'b0100 in cycle 0; cycle 1 shows out_SEND=1, out_DATA=0x5A, out_TAG=2, tokens_total=1.
REQ-031 All channels sending continuously with out_ACK held at 1 -> grants follow 0,1,2,3,0,... one per cycle; tokens_total=8 after 8 cycles.
REQ-032 Buffer FULL with out_ACK=0 for 5 cycles and in_SEND=4'b1111 -> in_ACK=0 throughout; out_DATA and out_TAG stable; tokens_total unchanged.
REQ-033 ptr=3 and in_SEND=4'b0011 -> channel 0 is granted, then channel 1 (wrap-around check).
REQ-034 RESET pulsed asynchronously between clock edges while FULL -> out_SEND falls before the next edge; tokens_total=0.
REQ-035 Counter wrap with CNT_W=4: 16 accepted tokens -> tokens_total returns to 0.
